// File: rtl/mem_responder_pkg.sv
// Shared parameters, state encoding and helpers for the mem_responder memory port.
// The MEM_MISALIGN_CHECK_EN macro (see mem_responder.sv) enables misaligned-access checking.
package mem_responder_pkg;

    localparam int unsigned MemWidth     = 32;
    localparam int unsigned MemDepthLog2 = 10;
    localparam int unsigned MemLatency   = 2;
    localparam int unsigned CntWidth     = 4;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StResp = 2'b10
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with write enable and a registered, held read port.
// Contents are never cleared; only the read register is reset.
module mem_array #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] mem [Depth];
    logic [WIDTH-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    // Read data only moves on a completed read; writes and idle cycles hold it.
    always_comb begin
        rdata_d = rdata_q;
        if (en_i && !we_i) begin
            rdata_d = mem[addr_i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Multicycle memory responder: IDLE -> WAIT (LATENCY cycles) -> RESP with a one-cycle ready pulse.
// Define MEM_MISALIGN_CHECK_EN to flag and suppress accesses with addr[1:0] != 0.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned WIDTH      = MemWidth,
    parameter int unsigned DEPTH_LOG2 = MemDepthLog2,
    parameter int unsigned LATENCY    = MemLatency
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             ready_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int unsigned AddrBits = DEPTH_LOG2 + 2;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [AddrBits-1:0]   addr_q, addr_d;
    logic                  we_q, we_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic                  access;
    logic                  misalign;
    logic                  mem_en;

    // Upper address bits alias onto the array and are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_i[WIDTH-1:AddrBits];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        access  = 1'b0;
        ready_o = 1'b0;
        busy_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    addr_d  = addr_i[AddrBits-1:0];
                    we_d    = we_i;
                    wdata_d = wdata_i;
                    cnt_d   = CntWidth'(LATENCY - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                busy_o = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    access  = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                busy_o  = 1'b1;
                ready_o = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign = is_misaligned(addr_q[1:0]);
    assign err_o    = (state_q == StResp) && misalign;
`else
    logic unused_addr_lo;
    assign unused_addr_lo = ^addr_q[1:0];
    assign misalign       = 1'b0;
    assign err_o          = 1'b0;
`endif

    // Gating with rst drops a write that coincides with a reset in the last WAIT cycle.
    assign mem_en = access && !misalign && !rst;

    mem_array #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem_array (
        .clk     (clk),
        .rst     (rst),
        .en_i    (mem_en),
        .we_i    (we_q),
        .addr_i  (addr_q[AddrBits-1:2]),
        .wdata_i (wdata_q),
        .rdata_o (rdata_o)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: expected responses are queued at issue and checked on ready.
module tb_mem_responder;

`ifdef MEM_MISALIGN_CHECK_EN
    localparam bit MisChk = 1'b1;
`else
    localparam bit MisChk = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          rcyc;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, we_r = 1'b0;
    logic [31:0] addr_r = '0, wdata_r = '0;
    logic [31:0] rdata;
    logic        ready, busy, err;

    logic        req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr1 = '0, wdata1 = '0;
    logic [31:0] rdata1;
    logic        ready1, busy1, err1;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    item_t       sb_q[$];
    logic [31:0] model_mem [1024];
    logic [31:0] hold = '0;
    logic        hold_en = 1'b0;
    logic        prev_ready = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(
        .WIDTH      (32),
        .DEPTH_LOG2 (10),
        .LATENCY    (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req),
        .we_i    (we_r),
        .addr_i  (addr_r),
        .wdata_i (wdata_r),
        .rdata_o (rdata),
        .ready_o (ready),
        .busy_o  (busy),
        .err_o   (err)
    );

    mem_responder #(
        .WIDTH      (32),
        .DEPTH_LOG2 (10),
        .LATENCY    (1)
    ) dut_l1 (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req1),
        .we_i    (we1),
        .addr_i  (addr1),
        .wdata_i (wdata1),
        .rdata_o (rdata1),
        .ready_o (ready1),
        .busy_o  (busy1),
        .err_o   (err1)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Issue one transaction on dut (LATENCY = 2) and wait for its ready pulse.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        item_t      it;
        logic       mis;
        logic [9:0] idx;
        logic       seen;
        idx = addr[11:2];
        mis = MisChk && (addr[1:0] != 2'b00);
        if (we) begin
            if (!mis) model_mem[idx] = wdata;
            it.rdata = hold;
        end else begin
            it.rdata = mis ? hold : model_mem[idx];
        end
        it.err = mis;
        @(posedge clk);
        #1;
        req     = 1'b1;
        we_r    = we;
        addr_r  = addr;
        wdata_r = wdata;
        it.rcyc = cyc + 1 + 2;
        sb_q.push_back(it);
        @(posedge clk);
        #1;
        // Scramble inputs: only the latched copies may matter now.
        req     = 1'b0;
        we_r    = ~we;
        addr_r  = ~addr;
        wdata_r = ~wdata;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        if (!seen) check_eq("ready_timeout", 32'(0), 32'(1));
        @(posedge clk);
    endtask

    task automatic do_reset();
        hold_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        hold = '0;
        @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_ready", 32'(ready), 32'(0));
        check_eq("rst_err", 32'(err), 32'(0));
        check_eq("rst_rdata", rdata, 32'h0);
        hold_en = 1'b1;
    endtask

    // Response monitor for dut.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (ready) begin
                check_eq("ready_adjacent", 32'(prev_ready), 32'(0));
                if (sb_q.size() == 0) begin
                    check_eq("spurious_ready", 32'(1), 32'(0));
                end else begin
                    it = sb_q.pop_front();
                    check_eq("ready_cycle", 32'(cyc), 32'(it.rcyc));
                    check_eq("rdata", rdata, it.rdata);
                    check_eq("err", 32'(err), 32'(it.err));
                    check_eq("busy_resp", 32'(busy), 32'(1));
                    hold = it.rdata;
                end
            end else if (hold_en && !rst) begin
                check_eq("rdata_hold", rdata, hold);
                check_eq("err_idle", 32'(err), 32'(0));
            end
            prev_ready = ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();

        do_txn(1'b1, 32'h10, 32'hDEADBEEF);
        do_txn(1'b0, 32'h10, 32'h0);
        do_txn(1'b1, 32'h14, 32'h12345678);
        repeat (3) @(posedge clk);

        // Aliasing: 0x1000 maps to word 0 with a 1024-word array.
        do_txn(1'b1, 32'h1000, 32'hA5A5A5A5);
        do_txn(1'b0, 32'h0, 32'h0);

        do_txn(1'b1, 32'h20, 32'hCAFEF00D);

        // Reset lands on the final WAIT cycle of a write; the write must be dropped.
        @(posedge clk);
        #1;
        req = 1'b1; we_r = 1'b1; addr_r = 32'h20; wdata_r = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        hold_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold = '0;
        @(negedge clk);
        check_eq("abort_busy", 32'(busy), 32'(0));
        check_eq("abort_ready", 32'(ready), 32'(0));
        check_eq("abort_rdata", rdata, 32'h0);
        hold_en = 1'b1;
        do_txn(1'b0, 32'h20, 32'h0);

        // Misaligned write: flagged and suppressed only when checking is enabled.
        do_txn(1'b1, 32'h22, 32'h11111111);
        do_txn(1'b0, 32'h20, 32'h0);

        // Continuous request on the LATENCY = 1 instance: one transaction per 3 cycles.
        @(posedge clk);
        #1;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h40; wdata1 = 32'h0BADF00D;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check_eq("b2b_ready", 32'(ready1), 32'((k % 3) == 2));
            check_eq("b2b_busy", 32'(busy1), 32'((k % 3) != 0));
            check_eq("b2b_err", 32'(err1), 32'(0));
        end
        @(posedge clk);
        #1;
        req1 = 1'b0;
        repeat (4) @(posedge clk);

        check_eq("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
